io_port_bank: RTL and testbench
===============================

// Module: io_port_bank
// PURPOSE
//  Parametrised multi-port GPIO bank for the Riskow SoC; successor to the fixed single-direction-register port pair.
//  Per port: output data, direction, synchronised input, set/clear/toggle strobes, per-pin edge interrupts.
//  Sits on the CPU data bus at a decoded base; pads/tristates live in top, driven from pin_out/pin_oe.
// PARAMETERS
//  WIDTH        32  pins per port
//  NUM_PORTS    2   number of ports (1..8)
//  SYNC_STAGES  2   input synchroniser depth (>=2)
//  ADDR_BITS    9   local byte-address width; port stride 0x40, so NUM_PORTS*0x40 <= 2**ADDR_BITS
// PORTS
//  clk             in   1                 single clock
//  reset           in   1                 synchronous, active-high
//  busValid        in   1                 request valid; master holds until busReady
//  busWriteEnable  in   1                 1=write, 0=read
//  busAddress      in   ADDR_BITS         local byte address, word aligned (bits[1:0] ignored)
//  busDataIn       in   32                write data (low WIDTH bits used)
//  busDataOut      out  32                read data, valid while busReady=1
//  busReady        out  1                 one-cycle completion pulse
//  pin_in          in   NUM_PORTS*WIDTH   raw pad inputs, asynchronous
//  pin_out         out  NUM_PORTS*WIDTH   output data to pads
//  pin_oe          out  NUM_PORTS*WIDTH   1=pin driven (output), 0=input/high-Z
//  irq             out  1                 level interrupt, OR of all enabled pending bits
// BEHAVIOUR
//  Reset: pin_out=0, pin_oe=0 (all inputs), irq=0, busReady=0, busDataOut=0, IRQ_EN/IRQ_EDGE/IRQ_STATUS=0.
//  Register map (offset within port; port p at p*0x40):
//   0x00 DATA_OUT rw | 0x04 DIRECTION rw | 0x08 DATA_IN ro (synchronised value)
//   0x0C OUT_SET wo W1S | 0x10 OUT_CLR wo W1C | 0x14 OUT_TGL wo W1T (read as 0)
//   0x18 IRQ_EN rw | 0x1C IRQ_EDGE rw (1=rising, 0=falling) | 0x20 IRQ_STATUS rw W1C
//  Handshake: request sampled when busValid=1 and busReady=0; busReady=1 exactly next cycle,
//   then 0 for >=1 cycle; no back-to-back accept. Read latency 1; write takes effect on accept edge.
//  Unmapped offset or port index >= NUM_PORTS: read returns 0, write ignored, busReady still pulses.
//  Upper 32-WIDTH read bits are 0. pin_out/pin_oe change the cycle after the accepted write.
//  Input path: SYNC_STAGES flops per pin, then one prev-value flop; edge = sync != prev.
//   Edge detection armed only after SYNC_STAGES+1 cycles post-reset; no status set before.
//   DATA_IN always reflects pads regardless of DIRECTION (loopback readable).
//  IRQ_STATUS bit sets on a matching edge regardless of IRQ_EN; irq = |(STATUS & EN) over all ports,
//   registered (one cycle after status/enable change).
//  Simultaneous W1C of a STATUS bit and a new matching edge on the same bit: set wins (bit stays 1).
//  Reset asserted mid-transaction: transaction dropped, busReady=0 next cycle, all state to reset values.
// STRUCTURE
//  Package riskow_io_pkg: register offset localparams, PORT_STRIDE=0x40, OFFSET_BITS=6.
//  Sub-module io_port_slice (one port: regs, synchroniser, edge/irq logic, pending output);
//   generated NUM_PORTS times; top decodes port index, muxes read data, ORs slice irqs, drives ready.
// TESTING
//  1 Reset then read all regs both ports -> 0 except DATA_IN=pad value; pin_oe=0, irq=0, busReady pulses once per access.
//  2 Write DIRECTION=0xFFFF_FFFF, DATA_OUT=0xA5A5_0000, OUT_SET=0x0F, OUT_CLR=0x0000_0001, OUT_TGL=0xFF00_0000
//    -> DATA_OUT reads 0x5AA5_000E, pin_out matches, pin_oe all ones.
//  3 Port1 IRQ_EDGE=0x1, IRQ_EN=0x1, drive pin_in[32] 0->1 -> STATUS bit0=1 after SYNC_STAGES+1 cycles, irq=1 next cycle;
//    write STATUS=0x1 -> irq=0; falling edge -> no set.
//  4 W1C of STATUS bit0 in same cycle as new rising edge on pin0 -> bit0 remains 1, irq stays 1.
//  5 Access offset 0x24 and port index 2 (NUM_PORTS=2) -> read 0, write no effect, busReady pulses.
//  6 Assert reset for 1 cycle while a read is pending -> busReady=0, pin_oe=0, pad held high yields no STATUS set before arming.

Source files
------------

// File: rtl/riskow_io_pkg.sv
// ---------------------------------------------------------------------------
// riskow_io_pkg
// Shared constants for the GPIO port bank: per-port register byte offsets,
// port stride and the width of the in-port offset field.
// ---------------------------------------------------------------------------
package riskow_io_pkg;

   localparam int PORT_STRIDE = 64;   // 0x40 bytes per port
   localparam int OFFSET_BITS = 6;    // log2(PORT_STRIDE)

   localparam logic [OFFSET_BITS-1:0] OFF_DATA_OUT   = 6'h00;
   localparam logic [OFFSET_BITS-1:0] OFF_DIRECTION  = 6'h04;
   localparam logic [OFFSET_BITS-1:0] OFF_DATA_IN    = 6'h08;
   localparam logic [OFFSET_BITS-1:0] OFF_OUT_SET    = 6'h0C;
   localparam logic [OFFSET_BITS-1:0] OFF_OUT_CLR    = 6'h10;
   localparam logic [OFFSET_BITS-1:0] OFF_OUT_TGL    = 6'h14;
   localparam logic [OFFSET_BITS-1:0] OFF_IRQ_EN     = 6'h18;
   localparam logic [OFFSET_BITS-1:0] OFF_IRQ_EDGE   = 6'h1C;
   localparam logic [OFFSET_BITS-1:0] OFF_IRQ_STATUS = 6'h20;

   // Byte offsets are word aligned; the two low address bits carry no meaning.
   function automatic logic [OFFSET_BITS-1:0] word_offset(input logic [OFFSET_BITS-1:0] a);
      return {a[OFFSET_BITS-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/io_port_slice.sv
// ---------------------------------------------------------------------------
// io_port_slice
// One GPIO port: output data / direction registers with set/clear/toggle
// strobes, input synchroniser, edge detector and interrupt status.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_wr            accepted write addressed to this port
//   i_offset        word-aligned register offset within the port
//   i_wdata         write data
//   i_pin_in        raw asynchronous pad inputs
//   o_rdata         read data for i_offset (combinational, registered by top)
//   o_pin_out       output data to pads
//   o_pin_oe        pad output enables (1 = driven)
//   o_irq_pend      OR of enabled pending status bits
// ---------------------------------------------------------------------------
module io_port_slice
   import riskow_io_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_wr,
   input  logic [OFFSET_BITS-1:0] i_offset,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic [WIDTH-1:0]       i_pin_in,
   output logic [WIDTH-1:0]       o_rdata,
   output logic [WIDTH-1:0]       o_pin_out,
   output logic [WIDTH-1:0]       o_pin_oe,
   output logic                   o_irq_pend
);

   localparam int                CNT_W     = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0]  ARM_COUNT = CNT_W'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_ien;
   logic [WIDTH-1:0] r_iedge;
   logic [WIDTH-1:0] r_stat;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [CNT_W-1:0] r_arm_cnt;

   logic             w_armed;
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_hit;
   logic [WIDTH-1:0] w_stat_clr;

   assign w_sync  = r_sync[SYNC_STAGES-1];
   // Edges are ignored until the synchroniser and prev flop hold real pad data.
   assign w_armed = (r_arm_cnt == ARM_COUNT);
   assign w_rise  = w_sync & ~r_prev;
   assign w_fall  = ~w_sync & r_prev;
   assign w_hit   = w_armed ? ((w_rise & r_iedge) | (w_fall & ~r_iedge)) : '0;

   assign o_pin_out  = r_out;
   assign o_pin_oe   = r_dir;
   assign o_irq_pend = |(r_stat & r_ien);

   // W1C mask for the interrupt status register
   always_comb begin
      w_stat_clr = '0;
      if (i_wr && (i_offset == OFF_IRQ_STATUS)) begin
         w_stat_clr = i_wdata;
      end else begin
         w_stat_clr = '0;
      end
   end

   // Input synchroniser, previous-value flop and post-reset arming counter
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_prev    <= '0;
         r_arm_cnt <= '0;
      end else begin
         r_sync[0] <= i_pin_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev    <= w_sync;
         r_arm_cnt <= w_armed ? r_arm_cnt : r_arm_cnt + CNT_W'(1);
      end
   end

   // Software-visible registers; a new edge overrides a same-cycle W1C
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out   <= '0;
         r_dir   <= '0;
         r_ien   <= '0;
         r_iedge <= '0;
         r_stat  <= '0;
      end else begin
         r_stat <= (r_stat & ~w_stat_clr) | w_hit;
         if (i_wr) begin
            case (i_offset)
               OFF_DATA_OUT:  r_out   <= i_wdata;
               OFF_DIRECTION: r_dir   <= i_wdata;
               OFF_OUT_SET:   r_out   <= r_out | i_wdata;
               OFF_OUT_CLR:   r_out   <= r_out & ~i_wdata;
               OFF_OUT_TGL:   r_out   <= r_out ^ i_wdata;
               OFF_IRQ_EN:    r_ien   <= i_wdata;
               OFF_IRQ_EDGE:  r_iedge <= i_wdata;
               default:       r_out   <= r_out;
            endcase
         end
      end
   end

   // Read multiplexer; strobe registers and holes read as zero
   always_comb begin
      o_rdata = '0;
      case (i_offset)
         OFF_DATA_OUT:   o_rdata = r_out;
         OFF_DIRECTION:  o_rdata = r_dir;
         OFF_DATA_IN:    o_rdata = w_sync;
         OFF_IRQ_EN:     o_rdata = r_ien;
         OFF_IRQ_EDGE:   o_rdata = r_iedge;
         OFF_IRQ_STATUS: o_rdata = r_stat;
         default:        o_rdata = '0;
      endcase
   end

endmodule

// File: rtl/io_port_bank.sv
// ---------------------------------------------------------------------------
// io_port_bank
// Multi-port GPIO bank on the CPU data bus. Decodes the port index from the
// upper address bits, forwards writes to one io_port_slice, returns read
// data one cycle after accept with a single-cycle busReady pulse, and
// combines the slice interrupt requests into one registered irq.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   busValid          request valid, held by the master until busReady
//   busWriteEnable    1 = write, 0 = read
//   busAddress        local byte address
//   busDataIn         write data
//   busDataOut        read data, valid while busReady = 1
//   busReady          one-cycle completion pulse
//   pin_in            raw pad inputs (NUM_PORTS*WIDTH)
//   pin_out, pin_oe   pad output data and output enables
//   irq               level interrupt
// ---------------------------------------------------------------------------
module io_port_bank
   import riskow_io_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int NUM_PORTS   = 2,
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_BITS   = 9
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       busValid,
   input  logic                       busWriteEnable,
   input  logic [ADDR_BITS-1:0]       busAddress,
   input  logic [31:0]                busDataIn,
   output logic [31:0]                busDataOut,
   output logic                       busReady,
   input  logic [NUM_PORTS*WIDTH-1:0] pin_in,
   output logic [NUM_PORTS*WIDTH-1:0] pin_out,
   output logic [NUM_PORTS*WIDTH-1:0] pin_oe,
   output logic                       irq
);

   localparam int IDX_W = ADDR_BITS - OFFSET_BITS;

   logic                   r_ready;
   logic                   r_irq;
   logic [31:0]            r_rdata;

   logic                   w_accept;
   logic [IDX_W-1:0]       w_port;
   logic [OFFSET_BITS-1:0] w_offset;
   logic [NUM_PORTS-1:0]   w_wr;
   logic [NUM_PORTS-1:0]   w_pend;
   logic [WIDTH-1:0]       w_slice_rd [NUM_PORTS];
   logic [31:0]            w_rdata;

   // A request is taken only while no completion is showing, so accepts
   // can never be back to back.
   assign w_accept = busValid & ~r_ready;
   assign w_port   = busAddress[ADDR_BITS-1:OFFSET_BITS];
   assign w_offset = word_offset(busAddress[OFFSET_BITS-1:0]);

   assign busReady   = r_ready;
   assign busDataOut = r_rdata;
   assign irq        = r_irq;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign w_wr[p] = w_accept & busWriteEnable & (w_port == IDX_W'(p));

      io_port_slice #(
         .WIDTH       (WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_slice (
         .clk        (clk),
         .reset      (reset),
         .i_wr       (w_wr[p]),
         .i_offset   (w_offset),
         .i_wdata    (busDataIn[WIDTH-1:0]),
         .i_pin_in   (pin_in[p*WIDTH +: WIDTH]),
         .o_rdata    (w_slice_rd[p]),
         .o_pin_out  (pin_out[p*WIDTH +: WIDTH]),
         .o_pin_oe   (pin_oe[p*WIDTH +: WIDTH]),
         .o_irq_pend (w_pend[p])
      );
   end

   // Port read-data select; indices beyond NUM_PORTS leave zero, upper bits stay zero
   always_comb begin
      w_rdata = 32'h0000_0000;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_port == IDX_W'(p)) begin
            w_rdata[WIDTH-1:0] = w_slice_rd[p];
         end else begin
            w_rdata = w_rdata;
         end
      end
   end

   // Bus completion, registered read data and combined interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ready <= 1'b0;
         r_rdata <= 32'h0000_0000;
         r_irq   <= 1'b0;
      end else begin
         r_ready <= w_accept;
         r_rdata <= (w_accept && !busWriteEnable) ? w_rdata : 32'h0000_0000;
         r_irq   <= |w_pend;
      end
   end

endmodule

// File: tb/tb_io_port_bank.sv
// ---------------------------------------------------------------------------
// tb_io_port_bank
// Directed plus randomized self-checking bench for io_port_bank.
// Expected register contents come from a behavioural model of the register
// map; expected interrupt status is computed from pad value transitions.
// ---------------------------------------------------------------------------
module tb_io_port_bank;
   import riskow_io_pkg::*;

   localparam int W  = 32;
   localparam int NP = 2;
   localparam int SS = 2;
   localparam int AB = 9;

   logic            clk;
   logic            reset;
   logic            busValid;
   logic            busWriteEnable;
   logic [AB-1:0]   busAddress;
   logic [31:0]     busDataIn;
   logic [31:0]     busDataOut;
   logic            busReady;
   logic [NP*W-1:0] pin_in;
   logic [NP*W-1:0] pin_out;
   logic [NP*W-1:0] pin_oe;
   logic            irq;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] m_out   [NP];
   logic [31:0] m_dir   [NP];
   logic [31:0] m_ien   [NP];
   logic [31:0] m_iedge [NP];
   logic [31:0] m_stat  [NP];

   io_port_bank #(.WIDTH(W), .NUM_PORTS(NP), .SYNC_STAGES(SS), .ADDR_BITS(AB)) dut (
      .clk            (clk),
      .reset          (reset),
      .busValid       (busValid),
      .busWriteEnable (busWriteEnable),
      .busAddress     (busAddress),
      .busDataIn      (busDataIn),
      .busDataOut     (busDataOut),
      .busReady       (busReady),
      .pin_in         (pin_in),
      .pin_out        (pin_out),
      .pin_oe         (pin_oe),
      .irq            (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [AB-1:0] ra(input int p, input logic [5:0] off);
      return AB'(p * PORT_STRIDE) | AB'(off);
   endfunction

   function automatic logic exp_irq();
      logic [31:0] acc;
      acc = 32'h0;
      for (int p = 0; p < NP; p++) acc = acc | (m_stat[p] & m_ien[p]);
      return |acc;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_out[p] = 32'h0; m_dir[p] = 32'h0; m_ien[p] = 32'h0;
         m_iedge[p] = 32'h0; m_stat[p] = 32'h0;
      end
   endtask

   task automatic model_wr(input int p, input logic [5:0] off, input logic [31:0] d);
      if (p < NP) begin
         case (off)
            OFF_DATA_OUT:   m_out[p]   = d;
            OFF_DIRECTION:  m_dir[p]   = d;
            OFF_OUT_SET:    m_out[p]   = m_out[p] | d;
            OFF_OUT_CLR:    m_out[p]   = m_out[p] & ~d;
            OFF_OUT_TGL:    m_out[p]   = m_out[p] ^ d;
            OFF_IRQ_EN:     m_ien[p]   = d;
            OFF_IRQ_EDGE:   m_iedge[p] = d;
            OFF_IRQ_STATUS: m_stat[p]  = m_stat[p] & ~d;
            default:        ;
         endcase
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One bus transfer: ready must come exactly one edge after the request and drop after.
   task automatic bus_xfer(input logic we, input logic [AB-1:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdat);
      int n;
      busValid = 1'b1; busWriteEnable = we; busAddress = addr; busDataIn = wd;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!busReady && n < 8);
      chk("ready_latency", 64'(n), 64'd1);
      rdat = busDataOut;
      busValid = 1'b0; busWriteEnable = 1'b0;
      @(posedge clk); #1;
      chk("ready_pulse", 64'(busReady), 64'd0);
   endtask

   task automatic wr(input int p, input logic [5:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      bus_xfer(1'b1, ra(p, off), d, dummy);
      model_wr(p, off, d);
   endtask

   task automatic rd(input string tag, input int p, input logic [5:0] off, input logic [31:0] exp);
      logic [31:0] d;
      bus_xfer(1'b0, ra(p, off), 32'h0, d);
      chk(tag, 64'(d), 64'(exp));
   endtask

   task automatic chk_pins(input string tag);
      chk({tag, "_pin_out"}, 64'(pin_out), {m_out[1], m_out[0]});
      chk({tag, "_pin_oe"},  64'(pin_oe),  {m_dir[1], m_dir[0]});
   endtask

   initial begin
      logic [5:0]  offs [9];
      logic [5:0]  wops [5];
      logic [31:0] d, oldv, newv;
      int          p, k;

      offs = '{OFF_DATA_OUT, OFF_DIRECTION, OFF_DATA_IN, OFF_OUT_SET, OFF_OUT_CLR,
               OFF_OUT_TGL, OFF_IRQ_EN, OFF_IRQ_EDGE, OFF_IRQ_STATUS};
      wops = '{OFF_DATA_OUT, OFF_DIRECTION, OFF_OUT_SET, OFF_OUT_CLR, OFF_OUT_TGL};

      reset = 1'b1; busValid = 1'b0; busWriteEnable = 1'b0;
      busAddress = '0; busDataIn = 32'h0;
      pin_in = {$urandom, $urandom};
      model_reset();

      // Reset state
      cycles(3);
      chk("rst_pin_out", 64'(pin_out), 64'h0);
      chk("rst_pin_oe", 64'(pin_oe), 64'h0);
      chk("rst_irq", 64'(irq), 64'h0);
      chk("rst_ready", 64'(busReady), 64'h0);
      chk("rst_dout", 64'(busDataOut), 64'h0);
      reset = 1'b0;
      cycles(5);

      // Every register of every port after reset
      for (int pp = 0; pp < NP; pp++) begin
         for (int i = 0; i < 9; i++) begin
            rd("rst_reg", pp, offs[i], (offs[i] == OFF_DATA_IN) ? pin_in[pp*W +: W] : 32'h0);
         end
      end
      chk("rst_irq2", 64'(irq), 64'h0);

      // Directed output-data sequence on port 0
      wr(0, OFF_DIRECTION, 32'hFFFF_FFFF);
      wr(0, OFF_DATA_OUT,  32'hA5A5_0000);
      wr(0, OFF_OUT_SET,   32'h0000_000F);
      wr(0, OFF_OUT_CLR,   32'h0000_0001);
      wr(0, OFF_OUT_TGL,   32'hFF00_0000);
      rd("seq_data_out", 0, OFF_DATA_OUT, 32'h5AA5_000E);
      chk("seq_pin_out", 64'(pin_out[31:0]), 64'h5AA5_000E);
      chk("seq_pin_oe0", 64'(pin_oe[31:0]), 64'hFFFF_FFFF);
      chk("seq_pin_oe1", 64'(pin_oe[63:32]), 64'h0);
      rd("seq_set_reads0", 0, OFF_OUT_SET, 32'h0);

      // Randomized output-register traffic against the model
      for (int i = 0; i < 24; i++) begin
         p = int'($urandom_range(0, NP - 1));
         k = int'($urandom_range(0, 4));
         wr(p, wops[k], $urandom);
         chk_pins("rnd");
      end
      for (int pp = 0; pp < NP; pp++) begin
         rd("rnd_data_out", pp, OFF_DATA_OUT, m_out[pp]);
         rd("rnd_dir", pp, OFF_DIRECTION, m_dir[pp]);
      end

      // Port 1 rising-edge interrupt on pin 32
      pin_in[63:32] = 32'h0;
      cycles(6);
      wr(1, OFF_IRQ_STATUS, 32'hFFFF_FFFF);
      wr(0, OFF_IRQ_STATUS, 32'hFFFF_FFFF);
      rd("clr_stat1", 1, OFF_IRQ_STATUS, 32'h0);
      wr(1, OFF_IRQ_EDGE, 32'h1);
      wr(1, OFF_IRQ_EN, 32'h1);
      chk("irq_idle", 64'(irq), 64'h0);
      pin_in[32] = 1'b1;
      cycles(SS + 1);
      chk("irq_before", 64'(irq), 64'h0);
      cycles(1);
      chk("irq_rise", 64'(irq), 64'h1);
      m_stat[1] = 32'h1;
      rd("stat_rise", 1, OFF_IRQ_STATUS, 32'h1);
      wr(1, OFF_IRQ_STATUS, 32'h1);
      chk("irq_w1c", 64'(irq), 64'h0);
      pin_in[32] = 1'b0;
      cycles(6);
      rd("stat_fall", 1, OFF_IRQ_STATUS, 32'h0);
      chk("irq_fall", 64'(irq), 64'h0);

      // W1C colliding with a new rising edge: the edge wins
      pin_in[32] = 1'b1;
      cycles(6);
      m_stat[1] = 32'h1;
      pin_in[32] = 1'b0;
      cycles(6);
      chk("irq_pre_coll", 64'(irq), 64'h1);
      pin_in[32] = 1'b1;
      cycles(SS);
      wr(1, OFF_IRQ_STATUS, 32'h1);
      m_stat[1] = 32'h1;
      rd("stat_coll", 1, OFF_IRQ_STATUS, 32'h1);
      chk("irq_coll", 64'(irq), 64'h1);
      wr(1, OFF_IRQ_STATUS, 32'h1);
      chk("irq_coll_clr", 64'(irq), 64'h0);

      // Randomized edge traffic on port 0
      wr(0, OFF_IRQ_EDGE, $urandom);
      wr(0, OFF_IRQ_EN, $urandom);
      for (int i = 0; i < 8; i++) begin
         oldv = pin_in[31:0];
         newv = $urandom;
         pin_in[31:0] = newv;
         cycles(6);
         m_stat[0] = m_stat[0] | (newv & ~oldv & m_iedge[0]) | (~newv & oldv & ~m_iedge[0]);
         rd("rnd_stat", 0, OFF_IRQ_STATUS, m_stat[0]);
         chk("rnd_irq", 64'(irq), 64'(exp_irq()));
         wr(0, OFF_IRQ_STATUS, $urandom);
         cycles(1);
         chk("rnd_irq_w1c", 64'(irq), 64'(exp_irq()));
      end

      // Holes and non-existent ports
      rd("hole_rd", 0, 6'h24, 32'h0);
      wr(0, 6'h24, $urandom);
      rd("hole_rd3c", 1, 6'h3C, 32'h0);
      rd("port2_rd", 2, OFF_DATA_OUT, 32'h0);
      wr(2, OFF_DATA_OUT, 32'hFFFF_FFFF);
      wr(2, OFF_DIRECTION, 32'hFFFF_FFFF);
      wr(7, OFF_OUT_TGL, 32'hFFFF_FFFF);
      rd("port7_rd", 7, OFF_DIRECTION, 32'h0);
      for (int pp = 0; pp < NP; pp++) begin
         rd("unmap_data_out", pp, OFF_DATA_OUT, m_out[pp]);
         rd("unmap_dir", pp, OFF_DIRECTION, m_dir[pp]);
      end
      chk_pins("unmap");

      // Reset on a pending read, then a held-high pad before arming
      busValid = 1'b1; busWriteEnable = 1'b0; busAddress = ra(0, OFF_DATA_IN);
      pin_in[31:0] = 32'hFFFF_FFFF;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; busValid = 1'b0;
      model_reset();
      chk("mid_rst_ready", 64'(busReady), 64'h0);
      chk("mid_rst_pin_oe", 64'(pin_oe), 64'h0);
      chk("mid_rst_pin_out", 64'(pin_out), 64'h0);
      chk("mid_rst_irq", 64'(irq), 64'h0);
      wr(0, OFF_IRQ_EDGE, 32'hFFFF_FFFF);
      wr(0, OFF_IRQ_EN, 32'hFFFF_FFFF);
      cycles(4);
      rd("arm_stat", 0, OFF_IRQ_STATUS, 32'h0);
      rd("arm_data_in", 0, OFF_DATA_IN, 32'hFFFF_FFFF);
      rd("arm_dir", 0, OFF_DIRECTION, 32'h0);
      chk("arm_irq", 64'(irq), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
